// File: rtl/q2fsm_run_logger.sv
// Measures runs of consecutive z=1 cycles and queues each completed length in a DEPTH-entry FIFO.
// A record appears one edge after the last high sample; a full FIFO without a same-cycle pop drops it.
module q2fsm_run_logger #(
   parameter int LEN_W = 8,
   parameter int DEPTH = 4,
   parameter int TOT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     z,
   input  logic                     clr,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [LEN_W-1:0]         out_len,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     run_active,
   output logic [TOT_W-1:0]         total_runs,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);

   logic             z_q;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW:0]      level;
   logic             run_end;
   logic             full;
   logic             pop;
   logic             push;

   always_comb begin
      run_end = z_q & ~z;
      full    = (level == (PW+1)'(DEPTH));
      pop     = out_valid & out_ready;
      // A full FIFO still takes the record when the head leaves in the same cycle.
      push    = run_end & (~full | pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         z_q        <= 1'b0;
         cnt        <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         total_runs <= '0;
         overflow   <= 1'b0;
      end else if (clr) begin
         z_q        <= 1'b0;
         cnt        <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         total_runs <= '0;
         overflow   <= 1'b0;
      end else begin
         z_q <= z;
         if (z) begin
            if (!z_q)
               cnt <= LEN_W'(1);
            else if (cnt != '1)
               cnt <= cnt + LEN_W'(1);
         end else if (z_q) begin
            cnt <= '0;
         end

         if (run_end) begin
            total_runs <= total_runs + TOT_W'(1);
            if (!push)
               overflow <= 1'b1;
         end

         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   level <= level + (PW+1)'(1);
            2'b01:   level <= level - (PW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clr)
         mem[wr_ptr] <= cnt;
   end

   assign out_valid  = (level != '0);
   assign out_len    = out_valid ? mem[rd_ptr] : '0;
   assign fifo_level = level;
   assign run_active = z_q;

endmodule

// File: tb/tb_q2fsm_run_logger.sv
// Directed vector bench for q2fsm_run_logger: one table row per clock edge, plus hand sequences.
module tb_q2fsm_run_logger;

   localparam int LEN_W = 8;
   localparam int DEPTH = 4;
   localparam int TOT_W = 16;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             z;
   logic             clr;
   logic             out_ready;
   logic             out_valid;
   logic [LEN_W-1:0] out_len;
   logic [LVL_W-1:0] fifo_level;
   logic             run_active;
   logic [TOT_W-1:0] total_runs;
   logic             overflow;

   q2fsm_run_logger #(.LEN_W(LEN_W), .DEPTH(DEPTH), .TOT_W(TOT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .z          (z),
      .clr        (clr),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_len    (out_len),
      .fifo_level (fifo_level),
      .run_active (run_active),
      .total_runs (total_runs),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             z;
      logic             clr;
      logic             rdy;
      logic             v;
      logic [LEN_W-1:0] len;
      logic [LVL_W-1:0] lvl;
      logic             act;
      logic [TOT_W-1:0] tot;
      logic             ovf;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic z_i, input logic clr_i, input logic rdy_i,
                               input logic v_i, input int len_i, input int lvl_i,
                               input logic act_i, input int tot_i, input logic ovf_i);
      vec_t r;
      r.z   = z_i;
      r.clr = clr_i;
      r.rdy = rdy_i;
      r.v   = v_i;
      r.len = LEN_W'(len_i);
      r.lvl = LVL_W'(lvl_i);
      r.act = act_i;
      r.tot = TOT_W'(tot_i);
      r.ovf = ovf_i;
      return r;
   endfunction

   task automatic add(input int rep, input logic z_i, input logic clr_i, input logic rdy_i,
                      input logic v_i, input int len_i, input int lvl_i,
                      input logic act_i, input int tot_i, input logic ovf_i);
      for (int k = 0; k < rep; k++)
         vq.push_back(mk(z_i, clr_i, rdy_i, v_i, len_i, lvl_i, act_i, tot_i, ovf_i));
   endtask

   task automatic check(input string name, input vec_t e);
      n_vec++;
      if (out_valid !== e.v || out_len !== e.len || fifo_level !== e.lvl ||
          run_active !== e.act || total_runs !== e.tot || overflow !== e.ovf) begin
         n_err++;
         $display("FAIL %s: got v=%0b len=%0d lvl=%0d act=%0b tot=%0d ovf=%0b, want v=%0b len=%0d lvl=%0d act=%0b tot=%0d ovf=%0b",
                  name, out_valid, out_len, fifo_level, run_active, total_runs, overflow,
                  e.v, e.len, e.lvl, e.act, e.tot, e.ovf);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      z         = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1 check("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      //   rep z clr rdy | v len lvl act tot ovf
      // Single run of 3, then one pop.
      add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      add(3, 1, 0, 0,   0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0,   1, 3, 1, 0, 1, 0);
      add(1, 0, 0, 1,   0, 0, 0, 0, 1, 0);
      // Runs 1..5 with no consumer: the fifth is dropped.
      add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0,   0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0,   1, 1, 1, 0, 1, 0);
      add(2, 1, 0, 0,   1, 1, 1, 1, 1, 0);
      add(1, 0, 0, 0,   1, 1, 2, 0, 2, 0);
      add(3, 1, 0, 0,   1, 1, 2, 1, 2, 0);
      add(1, 0, 0, 0,   1, 1, 3, 0, 3, 0);
      add(4, 1, 0, 0,   1, 1, 3, 1, 3, 0);
      add(1, 0, 0, 0,   1, 1, 4, 0, 4, 0);
      add(5, 1, 0, 0,   1, 1, 4, 1, 4, 0);
      add(1, 0, 0, 0,   1, 1, 4, 0, 5, 1);
      // Full FIFO: run of 2 completes together with a pop, then drain 2,3,4,2.
      add(2, 1, 0, 0,   1, 1, 4, 1, 5, 1);
      add(1, 0, 0, 1,   1, 2, 4, 0, 6, 1);
      add(1, 0, 0, 1,   1, 3, 3, 0, 6, 1);
      add(1, 0, 0, 1,   1, 4, 2, 0, 6, 1);
      add(1, 0, 0, 1,   1, 2, 1, 0, 6, 1);
      add(2, 0, 0, 1,   0, 0, 0, 0, 6, 1);
      // clr mid-run (cnt=6, two queued), z stays high: fresh run of 4.
      add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0,   0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0,   1, 1, 1, 0, 1, 0);
      add(1, 1, 0, 0,   1, 1, 1, 1, 1, 0);
      add(1, 0, 0, 0,   1, 1, 2, 0, 2, 0);
      add(6, 1, 0, 0,   1, 1, 2, 1, 2, 0);
      add(1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
      add(4, 1, 0, 0,   0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0,   1, 4, 1, 0, 1, 0);
      add(1, 0, 0, 1,   0, 0, 0, 0, 1, 0);

      for (int i = 0; i < vq.size(); i++) begin
         z         = vq[i].z;
         clr       = vq[i].clr;
         out_ready = vq[i].rdy;
         step();
         check($sformatf("vec%0d", i), vq[i]);
      end

      // Saturation: 300 high edges must report 255, not 300 mod 256.
      z = 1'b0; clr = 1'b1; out_ready = 1'b0;
      step();
      clr = 1'b0;
      z   = 1'b1;
      repeat (300) step();
      check("sat_high", mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
      z = 1'b0;
      step();
      check("sat_record", mk(0, 0, 0, 1, 255, 1, 0, 1, 0));

      // Asynchronous reset mid-run: outputs clear before any edge, partial run lost.
      z = 1'b1;
      repeat (3) step();
      check("pre_rst", mk(1, 0, 0, 1, 255, 1, 1, 1, 0));
      #2 reset = 1'b0;
      #1 check("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      z = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      step();
      check("rst_no_record", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
